// File: rtl/iod_word_align.sv
`default_nettype none
// ============================================================================
//  Module   : iod_word_align
//  Purpose  : Word-alignment controller for one ADC data lane. During link
//             training it compares each deserialized word against a known
//             training pattern. Until the word boundary is correct it issues
//             single-cycle bit-slip pulses to the deserializer. After that it
//             reports lock and forwards the data, registered once.
//  Ports    : clk_i          divided fabric clock, rising edge
//             rst_ni         asynchronous active-low reset
//             data_in_i      parallel word from the deserializer
//             train_req_i    start/restart alignment (IDLE, LOCKED, FAIL)
//             bitslip_o      one-cycle slip pulse to the deserializer
//             aligned_o      high while locked
//             align_fail_o   high while alignment has failed
//             slip_cnt_o     slips issued in the current training attempt
//             data_out_o     data_in_i registered once
//             data_valid_o   qualifies data_out_o (word sampled while locked)
//  Revision : 1.0  initial release
// ============================================================================
module iod_word_align #(
    parameter int unsigned       WIDTH         = 8,
    parameter logic [WIDTH-1:0]  PATTERN       = 8'hF0,
    parameter int unsigned       MATCH_COUNT   = 16,
    parameter int unsigned       SETTLE_CYCLES = 8,
    parameter int unsigned       MAX_SLIPS     = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             train_req_i,
    output logic             bitslip_o,
    output logic             aligned_o,
    output logic             align_fail_o,
    output logic [3:0]       slip_cnt_o,
    output logic [WIDTH-1:0] data_out_o,
    output logic             data_valid_o
);

    localparam int unsigned c_MATCH_W  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_MATCH_W-1:0]  c_MATCH_LAST  = c_MATCH_W'(MATCH_COUNT - 1);
    localparam logic [c_MATCH_W-1:0]  c_MATCH_FULL  = c_MATCH_W'(MATCH_COUNT);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);
    localparam logic [3:0]            c_MAX_SLIPS   = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_SETTLE = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t                 state_q;
    logic [c_MATCH_W-1:0]   match_cnt_q;
    logic [c_SETTLE_W-1:0]  settle_cnt_q;
    logic [3:0]             slip_cnt_q;
    logic                   bitslip_q;
    logic                   aligned_q;
    logic                   align_fail_q;
    logic [WIDTH-1:0]       data_out_q;
    logic                   data_valid_q;

    logic                   w_match;

    assign w_match = (data_in_i == PATTERN);

    // Status outputs are registered alongside the state: aligned/fail are set
    // on the edge that enters LOCKED/FAIL, while the slip pulse is raised on
    // the edge that leaves SLIP, so it lags the mismatch by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            match_cnt_q  <= '0;
            settle_cnt_q <= '0;
            slip_cnt_q   <= '0;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            align_fail_q <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_in_i;
            data_valid_q <= (state_q == S_LOCKED);
            bitslip_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (train_req_i) begin
                        state_q     <= S_CHECK;
                        match_cnt_q <= '0;
                        slip_cnt_q  <= '0;
                    end
                end

                S_CHECK: begin
                    if (w_match) begin
                        if (match_cnt_q == c_MATCH_LAST) begin
                            state_q   <= S_LOCKED;
                            aligned_q <= 1'b1;
                        end
                        if (match_cnt_q != c_MATCH_FULL) begin
                            match_cnt_q <= match_cnt_q + c_MATCH_W'(1);
                        end
                    end else begin
                        // Any mismatch discards partial progress toward lock.
                        match_cnt_q <= '0;
                        if (slip_cnt_q < c_MAX_SLIPS) begin
                            state_q <= S_SLIP;
                        end else begin
                            state_q      <= S_FAIL;
                            align_fail_q <= 1'b1;
                        end
                    end
                end

                S_SLIP: begin
                    bitslip_q    <= 1'b1;
                    settle_cnt_q <= c_SETTLE_LOAD;
                    state_q      <= S_SETTLE;
                    if (slip_cnt_q != 4'hF) begin
                        slip_cnt_q <= slip_cnt_q + 4'd1;
                    end
                end

                S_SETTLE: begin
                    // Stay here for SETTLE_CYCLES edges; the word sampled on the
                    // edge after the counter reaches zero is compared again.
                    settle_cnt_q <= settle_cnt_q - c_SETTLE_ONE;
                    if (settle_cnt_q <= c_SETTLE_ONE) begin
                        settle_cnt_q <= '0;
                        state_q      <= S_CHECK;
                        match_cnt_q  <= '0;
                    end
                end

                S_LOCKED: begin
                    if (train_req_i) begin
                        state_q     <= S_CHECK;
                        aligned_q   <= 1'b0;
                        match_cnt_q <= '0;
                        slip_cnt_q  <= '0;
                    end
                end

                S_FAIL: begin
                    if (train_req_i) begin
                        state_q      <= S_CHECK;
                        align_fail_q <= 1'b0;
                        match_cnt_q  <= '0;
                        slip_cnt_q   <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bitslip_o    = bitslip_q;
    assign aligned_o    = aligned_q;
    assign align_fail_o = align_fail_q;
    assign slip_cnt_o   = slip_cnt_q;
    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_iod_word_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iod_word_align
//  Purpose  : Self-checking bench for iod_word_align. A behavioural lane model
//             rotates the training word once per observed bit-slip and drives
//             junk while the controller is settling. Expected lock/fail edges
//             are computed arithmetically from the slip count and settle time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iod_word_align;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned MC    = 16;
    localparam int unsigned SC    = 8;
    localparam int unsigned MAXS  = 7;
    localparam logic [7:0]  PAT   = 8'hF0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       train = 1'b0;
    logic [7:0] din = 8'h00;
    logic       bitslip, aligned, align_fail, dvalid;
    logic [3:0] slip_cnt;
    logic [7:0] dout;

    iod_word_align #(
        .WIDTH(WIDTH), .PATTERN(PAT), .MATCH_COUNT(MC),
        .SETTLE_CYCLES(SC), .MAX_SLIPS(MAXS)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(din), .train_req_i(train),
        .bitslip_o(bitslip), .aligned_o(aligned), .align_fail_o(align_fail),
        .slip_cnt_o(slip_cnt), .data_out_o(dout), .data_valid_o(dvalid)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         bs_cycles = 0;
    int         junk = 0;
    int         lane_rot = 0;
    bit         lane_follow = 1'b0;
    bit         lane_dead = 1'b0;
    bit         live_rand = 1'b0;
    logic [7:0] dead_val = 8'h00;
    int         glitch_cyc = -1;
    logic [7:0] glitch_val = 8'hE1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lane_word();
        logic [15:0] p2;
        int          r;
        if (lane_dead) return dead_val;
        r  = lane_rot % 8;
        p2 = {PAT, PAT} << r;
        return p2[15:8];
    endfunction

    // One clock: check the registered data path, observe the slip pulse to
    // advance the lane model, then drive the next word.
    task automatic tick();
        logic [7:0] sent;
        bit         live;
        sent = din;
        live = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (live && rst_n) check_eq("dout", dout, sent);
        if (bitslip === 1'b1) begin
            bs_cycles++;
            if (lane_follow) lane_rot++;
            junk = SC;
        end
        if (junk > 0) begin
            din = 8'($urandom);
            junk--;
        end else if (cyc == glitch_cyc) begin
            din = glitch_val;
        end else if (live_rand) begin
            din = 8'($urandom);
        end else begin
            din = lane_word();
        end
    endtask

    task automatic set_lane(input int off, input bit follow, input bit dead);
        lane_rot    = (8 - off) % 8;
        lane_follow = follow;
        lane_dead   = dead;
        live_rand   = 1'b0;
        glitch_cyc  = -1;
        bs_cycles   = 0;
        junk        = 0;
        din         = lane_word();
    endtask

    task automatic start_train(input bit hold, output int k);
        train = 1'b1;
        tick();
        k = cyc;
        if (hold) tick();
        train = 1'b0;
    endtask

    task automatic wait_sig(input bit want_fail, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((want_fail ? align_fail : aligned) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bitslip"}, {31'd0, bitslip}, 32'd0);
        check_eq({tag, "_aligned"}, {31'd0, aligned}, 32'd0);
        check_eq({tag, "_fail"}, {31'd0, align_fail}, 32'd0);
        check_eq({tag, "_slipcnt"}, {28'd0, slip_cnt}, 32'd0);
        check_eq({tag, "_dvalid"}, {31'd0, dvalid}, 32'd0);
        check_eq({tag, "_dout"}, {24'd0, dout}, 32'd0);
    endtask

    initial begin
        int k, at, off, j;
        bit hold, seen;

        // Reset held with training pattern and request active.
        set_lane(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        train = 1'b1;
        repeat (3) tick();
        check_eq("reset_bs_count", bs_cycles, 0);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        k = cyc;
        train = 1'b0;
        wait_sig(1'b0, 100, at);
        check_eq("release_lock_edge", at, k + MC);
        check_eq("release_slipcnt", {28'd0, slip_cnt}, 32'd0);
        check_eq("release_bs_count", bs_cycles, 0);
        check_eq("dvalid_at_lock", {31'd0, dvalid}, 32'd0);

        // Live random data while locked: no checking, valid asserted.
        live_rand = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("locked_aligned", {31'd0, aligned}, 32'd1);
            check_eq("locked_dvalid", {31'd0, dvalid}, 32'd1);
        end
        check_eq("locked_bs_count", bs_cycles, 0);

        // Retrain from LOCKED on an aligned lane.
        set_lane(0, 1'b0, 1'b0);
        start_train(1'b0, k);
        check_eq("retrain_aligned_drop", {31'd0, aligned}, 32'd0);
        wait_sig(1'b0, 100, at);
        check_eq("retrain_lock_edge", at, k + MC);

        // Offset lane, random offsets (first trial offset 3).
        for (int t = 0; t < 6; t++) begin
            off  = (t == 0) ? 3 : int'($urandom_range(7, 0));
            hold = (t == 0) ? 1'b0 : 1'($urandom);
            set_lane(off, 1'b1, 1'b0);
            start_train(hold, k);
            wait_sig(1'b0, 400, at);
            check_eq("offset_lock_edge", at, k + off * (SC + 2) + MC);
            check_eq("offset_bs_count", bs_cycles, off);
            check_eq("offset_slipcnt", {28'd0, slip_cnt}, off);
            tick();
            check_eq("offset_dvalid", {31'd0, dvalid}, 32'd1);
        end

        // Dead lane: exhaust all slips, then fail; retrain clears it.
        do dead_val = 8'($urandom); while ($countones(dead_val) == 4);
        set_lane(0, 1'b1, 1'b1);
        start_train(1'b0, k);
        wait_sig(1'b1, 400, at);
        check_eq("dead_fail_edge", at, k + 1 + MAXS * (SC + 2));
        check_eq("dead_bs_count", bs_cycles, MAXS);
        check_eq("dead_slipcnt", {28'd0, slip_cnt}, MAXS);
        check_eq("dead_aligned", {31'd0, aligned}, 32'd0);
        repeat (5) tick();
        check_eq("dead_fail_held", {31'd0, align_fail}, 32'd1);
        check_eq("dead_slipcnt_frozen", {28'd0, slip_cnt}, MAXS);
        check_eq("dead_no_more_slips", bs_cycles, MAXS);
        set_lane(0, 1'b0, 1'b0);
        start_train(1'b0, k);
        check_eq("fail_clear", {31'd0, align_fail}, 32'd0);
        check_eq("fail_slipcnt_clear", {28'd0, slip_cnt}, 32'd0);
        wait_sig(1'b0, 100, at);
        check_eq("fail_relock_edge", at, k + MC);

        // Late mismatch after j matches restarts the count after one slip.
        for (int t = 0; t < 4; t++) begin
            j = (t == 0) ? 15 : int'($urandom_range(15, 0));
            set_lane(0, 1'b0, 1'b0);
            if (t == 0) glitch_val = 8'hE1;
            else do glitch_val = 8'($urandom); while (glitch_val == PAT);
            glitch_cyc = cyc + 1 + j;
            start_train(1'b0, k);
            wait_sig(1'b0, 200, at);
            check_eq("late_lock_edge", at, k + j + SC + 18);
            check_eq("late_bs_count", bs_cycles, 1);
            check_eq("late_slipcnt", {28'd0, slip_cnt}, 32'd1);
        end

        // Reset pulsed during SETTLE.
        do dead_val = 8'($urandom); while ($countones(dead_val) == 4);
        set_lane(0, 1'b1, 1'b1);
        start_train(1'b0, k);
        for (int i = 0; i < 50 && bs_cycles == 0; i++) tick();
        repeat (3) tick();
        check_eq("settle_pre_slipcnt", {28'd0, slip_cnt}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("settle_rst");
        #3 rst_n = 1'b1;
        bs_cycles = 0;
        repeat (20) tick();
        check_eq("settle_rst_idle_bs", bs_cycles, 0);
        check_eq("settle_rst_idle_slipcnt", {28'd0, slip_cnt}, 32'd0);
        check_eq("settle_rst_idle_fail", {31'd0, align_fail}, 32'd0);

        // Reset pulsed while BITSLIP is high.
        start_train(1'b0, k);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bitslip === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("bitslip_seen", {31'd0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("bitslip_async_drop", {31'd0, bitslip}, 32'd0);
        #3 rst_n = 1'b1;
        bs_cycles = 0;
        repeat (20) tick();
        check_eq("bitslip_rst_no_residual", bs_cycles, 0);

        // Fresh training after the abort.
        set_lane(0, 1'b0, 1'b0);
        start_train(1'b0, k);
        wait_sig(1'b0, 100, at);
        check_eq("abort_relock_edge", at, k + MC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
